// File: rtl/spi_pe_responder.sv
// spi_pe_responder: SPI mode-0 peripheral returning queued TX words on CIPO while capturing COPI words.
module spi_pe_responder #(
  parameter int DATA_WIDTH = 8,
  parameter int FIFO_DEPTH = 4,
  parameter logic [DATA_WIDTH-1:0] IDLE_WORD = '0
) (
  input  logic                  clk_in,
  input  logic                  rst_in,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  valid_in,
  output logic                  ready_out,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  data_valid_out,
  output logic                  underflow_out,
  output logic                  abort_out,
  input  logic                  chip_data_in,
  output logic                  chip_data_out,
  input  logic                  chip_clk_in,
  input  logic                  chip_sel_in
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam int BW = $clog2(DATA_WIDTH);
  typedef enum logic [1:0] {IDLE, LOAD, SHIFT} state_t;
  state_t state;
  logic [2:0] dclk_s, cs_s;
  logic [1:0] copi_s;
  logic dclk_rise, dclk_fall, cs_rise, cs_fall;
  logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] q_cnt, next_cnt;
  logic empty, push, pop;
  logic [DATA_WIDTH-1:0] load_word, rx_next;
  logic [DATA_WIDTH-2:0] tx_shift, rx_shift;
  logic [BW-1:0] bit_cnt;
  logic word_done;
  // CS flops reset high so a released bus right after reset produces no edge
  always_ff @(posedge clk_in)
    if (rst_in) begin
      dclk_s <= '0;
      cs_s   <= '1;
      copi_s <= '0;
    end else begin
      dclk_s <= {dclk_s[1:0], chip_clk_in};
      cs_s   <= {cs_s[1:0], chip_sel_in};
      copi_s <= {copi_s[0], chip_data_in};
    end
  assign dclk_rise = dclk_s[1] & ~dclk_s[2];
  assign dclk_fall = ~dclk_s[1] & dclk_s[2];
  assign cs_rise   = cs_s[1] & ~cs_s[2];
  assign cs_fall   = ~cs_s[1] & cs_s[2];
  assign empty     = q_cnt == '0;
  assign push      = valid_in && ready_out;
  assign pop       = state == LOAD && !empty && !cs_rise;
  assign next_cnt  = q_cnt + CW'(push) - CW'(pop);
  assign load_word = empty ? IDLE_WORD : mem[rd_ptr];
  assign rx_next   = {rx_shift, copi_s[1]};
  always_ff @(posedge clk_in)
    if (push) mem[wr_ptr] <= data_in;
  always_ff @(posedge clk_in)
    if (rst_in) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      q_cnt     <= '0;
      ready_out <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      q_cnt     <= next_cnt;
      ready_out <= next_cnt != CW'(FIFO_DEPTH);
    end
  always_ff @(posedge clk_in)
    if (rst_in) begin
      state          <= IDLE;
      tx_shift       <= '0;
      rx_shift       <= '0;
      bit_cnt        <= '0;
      word_done      <= 1'b0;
      data_out       <= '0;
      data_valid_out <= 1'b0;
      underflow_out  <= 1'b0;
      abort_out      <= 1'b0;
      chip_data_out  <= 1'b0;
    end else begin
      data_valid_out <= 1'b0;
      underflow_out  <= 1'b0;
      abort_out      <= 1'b0;
      case (state)
        IDLE: begin
          chip_data_out <= 1'b0;
          if (cs_fall) state <= LOAD;
        end
        LOAD: begin
          if (cs_rise) begin
            state         <= IDLE;
            chip_data_out <= 1'b0;
          end else begin
            tx_shift      <= load_word[DATA_WIDTH-2:0];
            chip_data_out <= load_word[DATA_WIDTH-1];
            underflow_out <= empty;
            bit_cnt       <= '0;
            word_done     <= 1'b0;
            state         <= SHIFT;
          end
        end
        SHIFT: begin
          if (cs_rise) begin
            state         <= IDLE;
            chip_data_out <= 1'b0;
            abort_out     <= bit_cnt != '0;
            bit_cnt       <= '0;
            word_done     <= 1'b0;
          end else if (dclk_rise) begin
            rx_shift <= rx_next[DATA_WIDTH-2:0];
            if (bit_cnt == BW'(DATA_WIDTH - 1)) begin
              data_out       <= rx_next;
              data_valid_out <= 1'b1;
              bit_cnt        <= '0;
              word_done      <= 1'b1;
            end else begin
              bit_cnt <= bit_cnt + 1'b1;
            end
          end else if (dclk_fall) begin
            if (word_done) state <= LOAD;
            else begin
              chip_data_out <= tx_shift[DATA_WIDTH-2];
              tx_shift      <= tx_shift << 1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_spi_pe_responder.sv
// tb_spi_pe_responder: directed plus randomized frames checked against a queue-based model of the responder.
module tb_spi_pe_responder;
  logic clk_in = 1'b0;
  logic rst_in = 1'b1;
  logic [7:0] data_in = '0;
  logic valid_in = 1'b0;
  logic ready_out;
  logic [7:0] data_out;
  logic data_valid_out, underflow_out, abort_out;
  logic chip_data_in = 1'b0;
  logic chip_data_out;
  logic chip_clk_in = 1'b0;
  logic chip_sel_in = 1'b1;
  int checks = 0;
  int errors = 0;
  int dv_n = 0;
  int uf_n = 0;
  int ab_n = 0;
  logic [7:0] model_q[$];

  spi_pe_responder dut (
    .clk_in(clk_in), .rst_in(rst_in), .data_in(data_in), .valid_in(valid_in),
    .ready_out(ready_out), .data_out(data_out), .data_valid_out(data_valid_out),
    .underflow_out(underflow_out), .abort_out(abort_out), .chip_data_in(chip_data_in),
    .chip_data_out(chip_data_out), .chip_clk_in(chip_clk_in), .chip_sel_in(chip_sel_in)
  );

  always #5 clk_in = ~clk_in;

  always @(negedge clk_in) begin
    if (data_valid_out) dv_n++;
    if (underflow_out) uf_n++;
    if (abort_out) ab_n++;
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk_in);
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [7:0] w);
    int t = 0;
    while (!ready_out && t < 200) begin
      tick(1);
      t++;
    end
    if (t >= 200) check("push_timeout", 32'(ready_out), 32'd1);
    valid_in = 1'b1;
    data_in  = w;
    tick(1);
    valid_in = 1'b0;
    model_q.push_back(w);
  endtask

  // One CS frame of nw words; abort_bits>=0 releases CS after that many rises of word 0.
  task automatic frame(input int nw, input int half, input int abort_bits, input bit push_en,
                       input logic [7:0] push_word, input int rx0);
    int dv0, uf0, ab0, exp_uf, done;
    bit aborted;
    logic [7:0] txw, rxw, got;
    dv0 = dv_n; uf0 = uf_n; ab0 = ab_n;
    exp_uf = 0; done = 0; aborted = 1'b0;
    chip_sel_in = 1'b0;
    tick(3);
    if (push_en) begin
      valid_in = 1'b1;
      data_in  = push_word;
    end
    tick(1);
    valid_in = 1'b0;
    for (int w = 0; w < nw; w++) begin
      if (model_q.size() > 0) txw = model_q.pop_front();
      else begin
        txw = 8'h00;
        exp_uf++;
      end
      if (w == 0 && push_en) model_q.push_back(push_word);
      rxw = (w == 0 && rx0 >= 0) ? 8'(rx0) : 8'($urandom);
      got = '0;
      for (int i = 7; i >= 0; i--) begin
        if (!(w == 0 && i == 7)) chip_clk_in = 1'b0;
        if (w == 0 && abort_bits == 7 - i) begin
          tick(half);
          chip_sel_in = 1'b1;
          aborted = 1'b1;
          break;
        end
        chip_data_in = rxw[i];
        tick(half);
        got[i] = chip_data_out;
        chip_clk_in = 1'b1;
        tick(half);
      end
      if (aborted) break;
      check($sformatf("cipo_word%0d", w), 32'(got), 32'(txw));
      check($sformatf("data_out_word%0d", w), 32'(data_out), 32'(rxw));
      done++;
    end
    if (!aborted) begin
      chip_sel_in = 1'b1;
      tick(2);
      chip_clk_in = 1'b0;
    end
    tick(10);
    check("data_valid_pulses", 32'(dv_n - dv0), 32'(done));
    check("underflow_pulses", 32'(uf_n - uf0), 32'(exp_uf));
    check("abort_pulses", 32'(ab_n - ab0), 32'(aborted));
    check("cipo_idle", 32'(chip_data_out), 32'd0);
  endtask

  initial begin
    logic [7:0] a, b;
    int dv0, uf0, ab0;
    tick(3);
    check("reset_ready", 32'(ready_out), 32'd0);
    check("reset_outputs", {data_out, data_valid_out, underflow_out, abort_out, chip_data_out}, 32'd0);
    rst_in = 1'b0;
    tick(1);
    check("ready_after_reset", 32'(ready_out), 32'd1);

    push(8'hA5);
    frame(1, 50, -1, 1'b0, 8'h00, 8'h3C);
    check("t1_data_out", 32'(data_out), 32'h3C);

    frame(1, 8, -1, 1'b0, 8'h00, -1);

    push(8'h11); push(8'h22); push(8'h33); push(8'h44);
    check("t3_full_ready", 32'(ready_out), 32'd0);
    valid_in = 1'b1;
    data_in  = 8'h55;
    tick(6);
    check("t3_held_off", 32'(ready_out), 32'd0);
    valid_in = 1'b0;
    frame(2, 8, -1, 1'b0, 8'h00, -1);
    check("t3_ready_again", 32'(ready_out), 32'd1);
    push(8'h55);
    frame(3, 7, -1, 1'b0, 8'h00, -1);

    push(8'($urandom)); push(8'($urandom)); push(8'($urandom));
    frame(1, 8, 3, 1'b0, 8'h00, -1);
    frame(2, 8, -1, 1'b0, 8'h00, -1);

    push(8'hC3); push(8'h5A);
    dv0 = dv_n; uf0 = uf_n; ab0 = ab_n;
    chip_sel_in = 1'b0;
    tick(4);
    for (int i = 0; i < 3; i++) begin
      chip_clk_in  = 1'b0;
      chip_data_in = 1'($urandom);
      tick(6);
      chip_clk_in = 1'b1;
      tick(6);
    end
    rst_in = 1'b1;
    chip_sel_in = 1'b1;
    chip_clk_in = 1'b0;
    tick(3);
    check("t5_reset_ready", 32'(ready_out), 32'd0);
    check("t5_reset_outputs", {data_out, data_valid_out, underflow_out, abort_out, chip_data_out}, 32'd0);
    rst_in = 1'b0;
    model_q.delete();
    tick(1);
    check("t5_ready_after", 32'(ready_out), 32'd1);
    tick(8);
    check("t5_no_pulses", 32'((dv_n - dv0) + (uf_n - uf0) + (ab_n - ab0)), 32'd0);
    frame(1, 8, -1, 1'b0, 8'h00, -1);
    a = 8'($urandom);
    b = 8'($urandom);
    push(a);
    frame(1, 8, -1, 1'b1, b, -1);
    frame(2, 8, -1, 1'b0, 8'h00, -1);

    for (int r = 0; r < 8; r++) begin
      int np;
      np = $urandom_range(0, 3);
      for (int k = 0; k < np && model_q.size() < 4; k++) push(8'($urandom));
      frame($urandom_range(1, 3), $urandom_range(6, 12), -1, 1'b0, 8'h00, -1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
